// File: rtl/regbank_rr_sched.sv
// Round-robin scheduler sharing a DEPTH x DW register bank between NREQ requesters and a {hi,lo} pack engine.
// Optional macro REGBANK_CONTENTION_CNT_EN adds a saturating 16-bit count of cycles with two or more slots requesting.
module regbank_rr_sched #(
  parameter int NREQ  = 4,
  parameter int DEPTH = 4,
  parameter int DW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ-1:0]              we,
  input  logic [NREQ*AW-1:0]           addr,
  input  logic [NREQ*DW-1:0]           wdata,
  output logic [NREQ-1:0]              gnt,
  output logic [DW-1:0]                rdata,
  output logic                         rvalid,
  output logic [$clog2(NREQ+1)-1:0]    rid,
  input  logic                         pack_req,
  input  logic [AW-1:0]                pack_hi_addr,
  input  logic [AW-1:0]                pack_lo_addr,
  output logic                         pack_ready,
  output logic                         pack_valid,
  output logic [2*DW-1:0]              pack_data,
`ifdef REGBANK_CONTENTION_CNT_EN
  output logic [15:0]                  contention_cnt,
`endif
  input  logic                         pack_ack
);
  localparam int RW = $clog2(NREQ+1);

  typedef enum logic [1:0] {IDLE, RD_HI, RD_LO, HOLD} pstate_t;

  pstate_t                  state, state_nxt;
  logic [DEPTH-1:0][DW-1:0] bank;
  logic [RW-1:0]            ptr;
  logic [AW-1:0]            hi_q, lo_q;
  logic [NREQ:0]            slot_req, gnt_all;
  logic                     gvalid, pack_rd, pack_gnt;
  logic [RW-1:0]            gidx;
  logic                     acc_we;
  logic [AW-1:0]            acc_addr;
  logic [DW-1:0]            acc_wdata, rd_val;

  // Slot NREQ is the pack engine; nothing requests while reset is held.
  assign pack_rd  = (state == RD_HI) || (state == RD_LO);
  assign slot_req = rst_n ? {pack_rd, req} : '0;

  always_comb begin
    int s;
    gvalid = 1'b0;
    gidx   = '0;
    s      = 0;
    for (int off = 0; off <= NREQ; off++) begin
      s = int'(ptr) + off;
      if (s > NREQ) s = s - (NREQ + 1);
      if (!gvalid && slot_req[s]) begin
        gvalid = 1'b1;
        gidx   = RW'(s);
      end
    end
  end

  always_comb begin
    gnt_all = '0;
    if (gvalid) gnt_all[gidx] = 1'b1;
  end

  assign gnt      = gnt_all[NREQ-1:0];
  assign pack_gnt = gnt_all[NREQ];

  always_comb begin
    acc_we    = 1'b0;
    acc_addr  = (state == RD_HI) ? hi_q : lo_q;
    acc_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_all[i]) begin
        acc_we    = we[i];
        acc_addr  = addr[i*AW +: AW];
        acc_wdata = wdata[i*DW +: DW];
      end
    end
  end

  assign rd_val = bank[acc_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank   <= '0;
      ptr    <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
      rid    <= '0;
    end else begin
      if (gvalid && acc_we) bank[acc_addr] <= acc_wdata;
      if (gvalid) ptr <= (gidx == RW'(NREQ)) ? '0 : gidx + 1'b1;
      rvalid <= gvalid && !acc_we && !pack_gnt;
      if (gvalid && !acc_we && !pack_gnt) begin
        rdata <= rd_val;
        rid   <= gidx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pack_req) state_nxt = RD_HI;
      RD_HI:   if (pack_gnt) state_nxt = RD_LO;
      RD_LO:   if (pack_gnt) state_nxt = HOLD;
      HOLD:    if (pack_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      pack_data <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && pack_req) begin
        hi_q <= pack_hi_addr;
        lo_q <= pack_lo_addr;
      end
      if (pack_gnt && state == RD_HI) pack_data[2*DW-1:DW] <= rd_val;
      if (pack_gnt && state == RD_LO) pack_data[DW-1:0]    <= rd_val;
    end
  end

  assign pack_ready = (state == IDLE);
  assign pack_valid = (state == HOLD);

`ifdef REGBANK_CONTENTION_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      contention_cnt <= '0;
    else if ($countones(slot_req) >= 2 && contention_cnt != 16'hFFFF)
      contention_cnt <= contention_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_regbank_rr_sched.sv
// Directed bench for regbank_rr_sched: table of single-cycle accesses plus pack/reset sequences.
module tb_regbank_rr_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0, we = '0, gnt;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [7:0]  rdata;
  logic        rvalid;
  logic [2:0]  rid;
  logic        pack_req = 1'b0, pack_ready, pack_valid, pack_ack = 1'b0;
  logic [1:0]  pack_hi_addr = '0, pack_lo_addr = '0;
  logic [15:0] pack_data;
`ifdef REGBANK_CONTENTION_CNT_EN
  logic [15:0] contention_cnt;
`endif

  int checks = 0;
  int errors = 0;

  regbank_rr_sched dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rdata(rdata), .rvalid(rvalid), .rid(rid),
    .pack_req(pack_req), .pack_hi_addr(pack_hi_addr), .pack_lo_addr(pack_lo_addr),
    .pack_ready(pack_ready), .pack_valid(pack_valid), .pack_data(pack_data),
`ifdef REGBANK_CONTENTION_CNT_EN
    .contention_cnt(contention_cnt),
`endif
    .pack_ack(pack_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  req;
    logic [3:0]  we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  exp_gnt;
    logic        exp_rv;
    logic [7:0]  exp_rdata;
    logic [2:0]  exp_rid;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req = '0; we = '0; pack_req = 1'b0; pack_ack = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic write_entry(input int i, input logic [1:0] a, input logic [7:0] d);
    req = '0; we = '0;
    req[i] = 1'b1; we[i] = 1'b1;
    addr[i*2 +: 2] = a;
    wdata[i*8 +: 8] = d;
    step();
    req = '0; we = '0;
  endtask

  task automatic read_entry(input logic [1:0] a, output logic [7:0] d, output logic v);
    req = 4'b0001; we = '0;
    addr[1:0] = a;
    step();
    d = rdata; v = rvalid;
    req = '0;
  endtask

  initial begin
    logic [7:0] d;
    logic       v;
    logic       bad;
    int         n;

    tv[0] = '{4'b0001, 4'b0001, 8'h02, 32'h0000_00A5, 4'b0001, 1'b0, 8'h00, 3'd0};
    tv[1] = '{4'b0001, 4'b0000, 8'h02, 32'h0000_0000, 4'b0001, 1'b1, 8'hA5, 3'd0};
    tv[2] = '{4'b0100, 4'b0100, 8'h10, 32'h003C_0000, 4'b0100, 1'b0, 8'h00, 3'd0};
    tv[3] = '{4'b1010, 4'b0000, 8'h84, 32'h0000_0000, 4'b1000, 1'b1, 8'hA5, 3'd3};
    tv[4] = '{4'b0010, 4'b0000, 8'h84, 32'h0000_0000, 4'b0010, 1'b1, 8'h3C, 3'd1};
    tv[5] = '{4'b0000, 4'b0000, 8'h00, 32'h0000_0000, 4'b0000, 1'b0, 8'h00, 3'd0};
    tv[6] = '{4'b1001, 4'b1001, 8'h03, 32'h1100_0077, 4'b1000, 1'b0, 8'h00, 3'd0};
    tv[7] = '{4'b0001, 4'b0001, 8'h03, 32'h0000_0077, 4'b0001, 1'b0, 8'h00, 3'd0};
    tv[8] = '{4'b0011, 4'b0000, 8'h0C, 32'h0000_0000, 4'b0010, 1'b1, 8'h77, 3'd1};
    tv[9] = '{4'b0001, 4'b0000, 8'h0C, 32'h0000_0000, 4'b0001, 1'b1, 8'h11, 3'd0};

    // Reset then idle
    do_reset();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_rvalid", rvalid, 1'b0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_rid", rid, 3'd0);
    chk("rst_pack_ready", pack_ready, 1'b1);
    chk("rst_pack_valid", pack_valid, 1'b0);
    chk("rst_pack_data", pack_data, 16'h0000);

    // Table of single-cycle accesses (pointer evolution hand-tracked)
    for (int k = 0; k < 10; k++) begin
      req = tv[k].req; we = tv[k].we; addr = tv[k].addr; wdata = tv[k].wdata;
      #1;
      chk($sformatf("tv%0d_gnt", k), gnt, tv[k].exp_gnt);
      step();
      chk($sformatf("tv%0d_rvalid", k), rvalid, tv[k].exp_rv);
      if (tv[k].exp_rv) begin
        chk($sformatf("tv%0d_rdata", k), rdata, tv[k].exp_rdata);
        chk($sformatf("tv%0d_rid", k), rid, tv[k].exp_rid);
      end
    end
    req = '0; we = '0;

    // Round-robin fairness from reset
    do_reset();
    req = 4'b1111; we = '0; addr = 8'h00;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("rr%0d_gnt", c), gnt, 4'b0001 << (c % 4));
      step();
      chk($sformatf("rr%0d_rid", c), rid, 3'(c % 4));
    end
    req = '0;

    // Pack with contention
    write_entry(0, 2'd0, 8'h12);
    write_entry(1, 2'd1, 8'h34);
    write_entry(2, 2'd3, 8'hF0);
    req = 4'b1111; we = '0; addr = 8'hE4;
    pack_req = 1'b1; pack_hi_addr = 2'd0; pack_lo_addr = 2'd1;
    #1;
    chk("pk_ready_before", pack_ready, 1'b1);
    step();
    pack_req = 1'b0;
    n = 0; bad = 1'b0;
    while (!pack_valid && n < 11) begin
      step();
      n++;
      if (rvalid && rid == 3'd4) bad = 1'b1;
    end
    chk("pk_valid_in_bound", pack_valid, 1'b1);
    chk("pk_no_rvalid", bad, 1'b0);
    chk("pk_data", pack_data, 16'h1234);
    req = '0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk($sformatf("pk_hold%0d_valid", c), pack_valid, 1'b1);
      chk($sformatf("pk_hold%0d_data", c), pack_data, 16'h1234);
    end
    pack_ack = 1'b1;
    step();
    pack_ack = 1'b0;
    chk("pk_ready_after_ack", pack_ready, 1'b1);
    chk("pk_valid_after_ack", pack_valid, 1'b0);

    // Pack hi==lo, ack ignored outside HOLD, pack_req ignored in HOLD
    pack_req = 1'b1; pack_hi_addr = 2'd3; pack_lo_addr = 2'd3;
    step();
    pack_req = 1'b0; pack_ack = 1'b1;
    step();
    pack_ack = 1'b0;
    n = 0;
    while (!pack_valid && n < 11) begin
      step();
      n++;
    end
    chk("pk2_valid_in_bound", pack_valid, 1'b1);
    chk("pk2_data", pack_data, 16'hF0F0);
    pack_req = 1'b1; pack_hi_addr = 2'd1; pack_lo_addr = 2'd2;
    step();
    pack_req = 1'b0;
    chk("pk2_req_ignored_valid", pack_valid, 1'b1);
    chk("pk2_req_ignored_data", pack_data, 16'hF0F0);
    pack_ack = 1'b1;
    step();
    pack_ack = 1'b0;
    chk("pk2_ready_after_ack", pack_ready, 1'b1);

    // Mid-pack reset in RD_LO
    pack_req = 1'b1; pack_hi_addr = 2'd0; pack_lo_addr = 2'd1;
    step();
    pack_req = 1'b0;
    step();
    chk("mr_busy", pack_ready, 1'b0);
    req = 4'b1111;
    rst_n = 1'b0;
    #1;
    chk("mr_gnt_in_reset", gnt, 4'b0000);
    chk("mr_ready_in_reset", pack_ready, 1'b1);
    chk("mr_pack_data", pack_data, 16'h0000);
    repeat (2) step();
    req = '0;
    rst_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (pack_valid || !pack_ready || rvalid) bad = 1'b1;
    end
    chk("mr_quiet_after", bad, 1'b0);
    read_entry(2'd0, d, v);
    chk("mr_rd0_valid", v, 1'b1);
    chk("mr_rd0_data", d, 8'h00);
    read_entry(2'd3, d, v);
    chk("mr_rd3_data", d, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/regbank_rr_sched.md
Name: regbank_rr_sched

Overview:
- Round-robin scheduler that shares one DEPTH x DW register bank among NREQ external requesters plus an internal pack engine.
- Grants one bank access per cycle: a write, or a read with registered return.
- The pack engine reads two entries on two granted cycles and returns them concatenated as {hi, lo}, width 2*DW, over a valid/ack handshake.
- Sits between byte-wide producers/consumers and the vector-packing datapath.

Parameters:
NREQ, 4, number of external requesters (>=2)
DEPTH, 4, register bank entries (power of 2)
DW, 8, entry width in bits
AW, $clog2(DEPTH), address width (derived; do not override)

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester access request; held with payload until granted
we  input  NREQ  per-requester write enable (1=write, 0=read)
addr  input  NREQ*AW  per-requester address; slice i belongs to requester i
wdata  input  NREQ*DW  per-requester write data; slice i belongs to requester i
gnt  output  NREQ  one-hot combinational grant; access commits at the posedge where gnt[i]=1
rdata  output  DW  registered read data
rvalid  output  1  one-cycle pulse; rdata valid for read granted in previous cycle
rid  output  $clog2(NREQ+1)  requester index that owns rdata
pack_req  input  1  pack command; accepted when pack_req & pack_ready
pack_hi_addr  input  AW  entry placed in upper half of pack_data
pack_lo_addr  input  AW  entry placed in lower half of pack_data
pack_ready  output  1  pack engine idle
pack_valid  output  1  pack result held valid
pack_data  output  2*DW  {bank[hi], bank[lo]}
pack_ack  input  1  consumer accepts pack_data

Behaviour:
- Reset (rst_n=0, async): all bank entries=0, rr pointer=0, rvalid=0, rdata=0, rid=0, pack FSM=IDLE, pack_valid=0, pack_data=0. gnt is combinationally 0 while in reset.
- Arbitration slots are 0..NREQ-1 for external requesters and slot NREQ for the pack engine.
  - The winner is the first requesting slot found scanning upward from pointer, wrapping modulo NREQ+1.
  - After a grant to slot k, pointer <= (k+1) mod (NREQ+1). With no grant, pointer holds.
  - At most one grant per cycle. Non-granted requesters must hold req/we/addr/wdata stable.
- Write commit: bank[addr_k] <= wdata_k at the posedge with the grant. No rvalid.
- Read commit: rdata <= bank[addr_k], rvalid <= 1, rid <= k on the next cycle.
  - Latency is 1 cycle after the grant edge.
  - A read returns the pre-write value if a write to the same address committed on the same edge. Cannot occur, since there is only one access per cycle.
  - A read in the cycle after a write sees the new value.
- Pack FSM:
  - IDLE: pack_ready=1. On pack_req, capture hi/lo addresses and go to RD_HI.
  - RD_HI: slot NREQ requests a read of hi. On grant, latch the value into pack_data[2*DW-1:DW] and go to RD_LO.
  - RD_LO: slot NREQ requests a read of lo. On grant, latch the value into pack_data[DW-1:0] and go to HOLD.
  - HOLD: pack_valid=1, pack_data stable. On pack_ack, go to IDLE.
  - Pack reads do not pulse rvalid.
  - hi==lo is legal and gives {v,v}. Minimum pack latency is 3 cycles from acceptance to pack_valid.
  - pack_ack outside HOLD is ignored. pack_req outside IDLE is ignored.
- Starvation bound: any held request is granted within NREQ+1 cycles.
- Reset mid-operation: the FSM aborts to IDLE, bank contents clear, and in-flight reads are dropped (no rvalid).

Optional Feature:
- Macro REGBANK_CONTENTION_CNT_EN.
- When defined:
  - Adds output port contention_cnt, 16 bits.
  - Counts cycles in which two or more slots request simultaneously.
  - Saturates at 16'hFFFF. Reset value is 0.
- When not defined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset then idle: hold rst_n=0 then release with no req -> gnt=0, rvalid=0, pack_ready=1, pack_data=16'h0000.
- Single write/readback: req0 writes 8'hA5 to addr 2, then req0 reads addr 2 -> gnt=4'b0001 on each access; rvalid the cycle after the read grant with rdata=8'hA5, rid=0.
- Round-robin fairness: req=4'b1111 held continuously from reset -> grant order 0,1,2,3,0,... (pack idle); each requester gets exactly 1 grant per 4 cycles.
- Pack with contention:
  - Preload bank[0]=8'h12 and bank[1]=8'h34.
  - pack_req with hi=0, lo=1 while req=4'b1111 held.
  - Expect pack_valid within 2*(NREQ+1)+1 cycles with pack_data=16'h1234, held until pack_ack.
  - Next pack_ready=1 one cycle after the ack.
- Pack hi==lo: bank[3]=8'hF0, hi=lo=3 -> pack_data=16'hF0F0.
- Mid-pack reset: assert rst_n=0 in RD_LO -> pack_valid stays 0, pack_ready=1 after release, bank reads return 8'h00.
